// File: rtl/amoa_pkg.sv
// Shared constants, FSM state and result record for the ApxRT operand-side issue controller.
package amoa_pkg;

    localparam int N_OPS   = 8;
    localparam int OP_W    = 8;
    localparam int SUM_W   = 11;
    localparam int APX_LAT = 2;

    typedef enum logic {
        RUN = 1'b0,
        FIX = 1'b1
    } state_e;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             exact;
    } result_t;

endpackage

// File: rtl/amoa_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count; head reads as zero while empty.
module amoa_res_fifo
    import amoa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  result_t                  push_data,
    input  logic                     pop,
    output result_t                  pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    result_t            mem_q [DEPTH];
    result_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream credit accounting must make this unreachable.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/amoa_rt8_issue_ctrl.sv
// Issue/collect controller for the 8x8 ApxRT adder: approximate results pass through, flagged sets
// are recomputed exactly by an 8-cycle accumulator. Optional macro AMOA_ERRCNT_EN adds err_cnt.
module amoa_rt8_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = 8,
    parameter int SUM_W      = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*OP_W-1:0]    in_data,
    output logic [OP_W-1:0]      x0,
    output logic [OP_W-1:0]      x1,
    output logic [OP_W-1:0]      x2,
    output logic [OP_W-1:0]      x3,
    output logic [OP_W-1:0]      x4,
    output logic [OP_W-1:0]      x5,
    output logic [OP_W-1:0]      x6,
    output logic [OP_W-1:0]      x7,
    input  logic [SUM_W-1:0]     apx_summ,
    input  logic                 apx_ed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_W-1:0]     out_sum,
    output logic                 out_exact
`ifdef AMOA_ERRCNT_EN
    ,
    output logic [15:0]          err_cnt
`endif
);

    import amoa_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e                   state_q, state_d;
    logic [APX_LAT-1:0]       tag_q, tag_d;
    logic [N_OPS*OP_W-1:0]    fix_data_q, fix_data_d;
    logic [SUM_W-1:0]         acc_q, acc_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     fix_done_q, fix_done_d;
    logic [OP_W-1:0]          fix_op;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_empty;
    result_t                  fifo_head;
    result_t                  push_data;
    logic                     push;
    logic                     pop;
    logic                     credit_ok;
    logic                     accept;
    logic                     clean_accept;
    logic                     err_accept;
    int                       inflight;

    assign x0 = in_data[0*OP_W +: OP_W];
    assign x1 = in_data[1*OP_W +: OP_W];
    assign x2 = in_data[2*OP_W +: OP_W];
    assign x3 = in_data[3*OP_W +: OP_W];
    assign x4 = in_data[4*OP_W +: OP_W];
    assign x5 = in_data[5*OP_W +: OP_W];
    assign x6 = in_data[6*OP_W +: OP_W];
    assign x7 = in_data[7*OP_W +: OP_W];

    assign fix_op = fix_data_q[cnt_q*OP_W +: OP_W];

    // A set being fixed holds one credit so its result always has a FIFO slot.
    always_comb begin
        inflight = (state_q == FIX) ? 1 : 0;
        for (int i = 0; i < APX_LAT; i++) begin
            inflight = inflight + int'(tag_q[i]);
        end
        credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (err_accept) state_d = FIX;
            FIX:     if (fix_done_q) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready       = rst_n && (state_q == RUN) && credit_ok;
        accept         = in_valid && in_ready;
        clean_accept   = accept && !apx_ed;
        err_accept     = accept && apx_ed;
        push           = 1'b0;
        push_data      = '0;
        if (tag_q[APX_LAT-1]) begin
            push           = 1'b1;
            push_data.sum  = apx_summ;
        end else if ((state_q == FIX) && fix_done_q) begin
            push            = 1'b1;
            push_data.sum   = acc_q;
            push_data.exact = 1'b1;
        end
        pop = out_valid && out_ready;
    end

    // The flagged set's own adder output is never tagged, so it falls out of the pipe unused.
    always_comb begin
        tag_d      = {tag_q[APX_LAT-2:0], clean_accept};
        fix_data_d = fix_data_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        fix_done_d = fix_done_q;
        if (err_accept) begin
            fix_data_d = in_data;
            acc_d      = '0;
            cnt_d      = '0;
            fix_done_d = 1'b0;
        end else if ((state_q == FIX) && !fix_done_q) begin
            acc_d = acc_q + SUM_W'(fix_op);
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(N_OPS - 1)) begin
                fix_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q      <= '0;
            fix_data_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            fix_done_q <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            fix_data_q <= fix_data_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            fix_done_q <= fix_done_d;
        end
    end

`ifdef AMOA_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_accept && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    amoa_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_sum   = fifo_head.sum;
    assign out_exact = fifo_head.exact;

endmodule

// File: doc/amoa_rt8_issue_ctrl.md
Name: amoa_rt8_issue_ctrl

Overview:
Issue/collect controller at the operand end of the 8x8-bit approximate multi-operand adder (ApxRT, 2-cycle latency, combinational error-detect/stall flag).
- Accepts packed 8-operand sets from upstream via valid/ready and drives them to the adder.
- Consumes the adder's error flag. Clean sets return the adder's approximate sum; flagged sets are recomputed exactly by a sequential 8-cycle accumulator.
- Returns results in order through a credit-protected result FIFO.

Parameters:
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2); also the credit limit on in-flight plus buffered results
OP_W, 8, operand width (fixed by the adder)
SUM_W, 11, result width = OP_W+3

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream operand set valid
in_ready  out  1  controller accepts set this cycle
in_data  in  64  operand k = in_data[8k+7:8k], k=0..7
x0..x7  out  8 each  adder operands; combinationally = in_data slices
apx_summ  in  11  adder registered sum
apx_ed  in  1  adder error-detect (stall); combinational from x0..x7
out_valid  out  1  result available (FIFO head)
out_ready  in  1  downstream accepts result
out_sum  out  11  result
out_exact  out  1  1 = result from exact fix path, 0 = approximate

Behaviour:
- Reset state: rst_n is asynchronous, active-low; clock is clk. During reset, in_ready=0, out_valid=0, out_sum=0, out_exact=0, FIFO empty, in-flight tags cleared, FSM=RUN, accumulator=0.
- Credit: credit_ok = (fifo_count + inflight) < FIFO_DEPTH. inflight = number of set bits in the 2-stage tag pipeline, plus 1 while in FIX.
- in_ready = (state==RUN) && credit_ok.
- Accept: an accept occurs in cycle T when in_valid && in_ready. apx_ed is sampled in the same cycle T.
- Clean accept (apx_ed=0): push tag into a 2-stage shift pipeline.
  - At T+2, apx_summ is pushed into the FIFO with exact=0.
  - out_valid rises at T+3 at the earliest.
- Errored accept (apx_ed=1): the adder's eventual output for that set is ignored (no tag is pushed).
  - Capture in_data into the fix register; FSM goes RUN->FIX.
  - FIX cycles 1..8 (T+1..T+8): acc <= acc + zero-extended operand[cnt], with acc cleared on entry; 3-bit cnt.
  - At T+9: push acc into the FIFO with exact=1; FSM goes FIX->RUN.
  - in_ready=0 throughout FIX. Ordering is preserved because older clean tags drain by T+2.
- FIFO: first-word-fall-through.
  - out_sum and out_exact are valid whenever out_valid=1 and are held stable until out_ready.
  - A pop and a push in the same cycle are both performed.
  - The credit rule guarantees a push never hits a full FIFO. A simulation assertion fires if it does.
- Arithmetic: 8 x 255 = 2040 fits in 11 bits; no overflow is possible.
- Reset mid-FIX: the set is dropped, no output is produced, and the controller resumes in RUN with full credit.

Optional Feature:
AMOA_ERRCNT_EN:
- When defined: adds output port err_cnt [15:0], reset 0. It increments by 1 on each errored accept and saturates at 16'hFFFF.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package amoa_pkg holds:
  - constants N_OPS=8, OP_W=8, SUM_W=11, APX_LAT=2
  - FSM state enum {RUN, FIX}
  - result struct {sum[10:0], exact}
- One sub-module, amoa_res_fifo: parameterised-depth FWFT sync FIFO with count output. It is instantiated once for results.

Test Plan:
- Clean set: all operands 8'h01 -> accept at T; out_valid at T+3 with out_sum=11'd8, out_exact=0.
- Errored set: all operands 8'hFF, so apx_ed=1 -> in_ready=0 for T+1..T+9; out_sum=11'd2040 (0x7F8), out_exact=1 at T+10; err_cnt=1 if AMOA_ERRCNT_EN.
- Ordering: back-to-back clean(all 2) / errored(all FF) / clean(all 3) -> outputs in order 16 (approx), 2040 (exact), 24 (approx); the third set stalls until FIX ends.
- Backpressure: out_ready=0, in_valid held high with clean sets -> exactly 4 accepts, then in_ready=0. With out_ready=1 for one cycle, one pop occurs and one more accept follows (credit refilled).
- Reset mid-FIX: assert rst_n=0 at FIX cycle 4 -> no result emitted, FIFO empty, err_cnt=0; next clean set of all 1s returns 8 at accept+3.
- Saturation (AMOA_ERRCNT_EN): preload err_cnt to 16'hFFFE via force, then 3 errored sets -> err_cnt=16'hFFFF and it stays there.
